// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: change codes, dispenser FSM states and
// the coin-select encoding used on the ejector interface.
package vend_pkg;

    localparam logic [2:0] CHG_0  = 3'd0;
    localparam logic [2:0] CHG_5  = 3'd1;
    localparam logic [2:0] CHG_10 = 3'd2;
    localparam logic [2:0] CHG_15 = 3'd3;
    localparam logic [2:0] CHG_20 = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VEND   = 3'd1,
        ST_SELECT = 3'd2,
        ST_EJECT  = 3'd3,
        ST_DONE   = 3'd4
    } disp_state_e;

    typedef enum logic {
        COIN_NICKEL = 1'b0,
        COIN_DIME   = 1'b1
    } coin_e;

    function automatic logic chg_legal(input logic [2:0] code);
        return code <= CHG_20;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Controller-side and ejector/motor-side signals of the change dispenser.
// The master drives requests and acknowledges; the slave is the dispenser.
interface change_dispenser_if #(parameter int CNT_W = 4);

    logic             soda_i;
    logic [2:0]       change_i;
    logic             vend_motor_o;
    logic             vend_done_i;
    logic             eject_req_o;
    logic             eject_dime_o;
    logic             eject_ack_i;
    logic             refill_i;
    logic             busy_o;
    logic             done_o;
    logic             drop_o;
    logic             fault_o;
    logic [CNT_W-1:0] nickel_cnt_o;
    logic [CNT_W-1:0] dime_cnt_o;

    modport master (
        output soda_i, change_i, vend_done_i, eject_ack_i, refill_i,
        input  vend_motor_o, eject_req_o, eject_dime_o, busy_o, done_o,
               drop_o, fault_o, nickel_cnt_o, dime_cnt_o
    );

    modport slave (
        input  soda_i, change_i, vend_done_i, eject_ack_i, refill_i,
        output vend_motor_o, eject_req_o, eject_dime_o, busy_o, done_o,
               drop_o, fault_o, nickel_cnt_o, dime_cnt_o
    );

endinterface

// File: rtl/handshake_timer.sv
// Wait-cycle counter shared by the motor and ejector handshakes; expired is
// high during the waiting cycle that brings the count to ACK_TIMEOUT.
module handshake_timer #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    logic [TW-1:0] cnt_q;

    assign expired = run && (cnt_q == TW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (run && !expired) begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Vending back-end: runs the soda motor, then pays change coin-by-coin from
// the nickel/dime hoppers over a req/ack ejector handshake.
//
//   state  | meaning
//   IDLE   | waiting for soda_i; refill_i honoured here
//   VEND   | motor on, waiting for vend_done_i
//   SELECT | one cycle choosing the next coin (dime first, never overpay)
//   EJECT  | coin request held, waiting for eject_ack_i
//   DONE   | one-cycle done_o, back to IDLE
module change_dispenser
    import vend_pkg::*;
#(
    parameter int NICKEL_INIT = 8,
    parameter int DIME_INIT   = 8,
    parameter int CNT_W       = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    change_dispenser_if.slave bus
);

    localparam logic [CNT_W-1:0] N_INIT = CNT_W'(NICKEL_INIT);
    localparam logic [CNT_W-1:0] D_INIT = CNT_W'(DIME_INIT);

    disp_state_e      state_q, state_nx;
    logic [2:0]       rem_q, rem_nx;
    logic [CNT_W-1:0] nickel_q, nickel_nx;
    logic [CNT_W-1:0] dime_q, dime_nx;
    logic             fault_q, fault_nx;
    coin_e            coin_q, coin_nx;
    logic             motor_q, req_q, dime_out_q, busy_q, done_q, drop_q;
    logic             waiting, expired;

    assign waiting = (state_q == ST_VEND) || (state_q == ST_EJECT);

    handshake_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (!waiting),
        .run     (waiting),
        .expired (expired)
    );

    always_comb begin
        state_nx  = state_q;
        rem_nx    = rem_q;
        nickel_nx = nickel_q;
        dime_nx   = dime_q;
        fault_nx  = fault_q;
        coin_nx   = coin_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.refill_i) begin
                    nickel_nx = N_INIT;
                    dime_nx   = D_INIT;
                    fault_nx  = 1'b0;
                end
                if (bus.soda_i) begin
                    if (chg_legal(bus.change_i)) begin
                        rem_nx   = bus.change_i;
                        state_nx = ST_VEND;
                    end else begin
                        fault_nx = 1'b1;
                    end
                end
            end
            ST_VEND: begin
                if (bus.vend_done_i) begin
                    state_nx = (rem_q == 3'd0) ? ST_DONE : ST_SELECT;
                end else if (expired) begin
                    fault_nx = 1'b1;
                    rem_nx   = 3'd0;
                    state_nx = ST_DONE;
                end
            end
            ST_SELECT: begin
                if (rem_q >= 3'd2 && dime_q != '0) begin
                    coin_nx  = COIN_DIME;
                    state_nx = ST_EJECT;
                end else if (nickel_q != '0) begin
                    coin_nx  = COIN_NICKEL;
                    state_nx = ST_EJECT;
                end else begin
                    fault_nx = 1'b1;
                    rem_nx   = 3'd0;
                    state_nx = ST_DONE;
                end
            end
            ST_EJECT: begin
                // ack beats a timeout landing on the same edge
                if (bus.eject_ack_i) begin
                    if (coin_q == COIN_DIME) begin
                        rem_nx  = rem_q - 3'd2;
                        dime_nx = dime_q - CNT_W'(1);
                    end else begin
                        rem_nx    = rem_q - 3'd1;
                        nickel_nx = nickel_q - CNT_W'(1);
                    end
                    state_nx = (rem_nx == 3'd0) ? ST_DONE : ST_SELECT;
                end else if (expired) begin
                    fault_nx = 1'b1;
                    rem_nx   = 3'd0;
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            rem_q      <= 3'd0;
            nickel_q   <= N_INIT;
            dime_q     <= D_INIT;
            fault_q    <= 1'b0;
            coin_q     <= COIN_NICKEL;
            motor_q    <= 1'b0;
            req_q      <= 1'b0;
            dime_out_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_nx;
            rem_q      <= rem_nx;
            nickel_q   <= nickel_nx;
            dime_q     <= dime_nx;
            fault_q    <= fault_nx;
            coin_q     <= coin_nx;
            motor_q    <= (state_nx == ST_VEND);
            req_q      <= (state_nx == ST_EJECT);
            dime_out_q <= (state_nx == ST_EJECT) && (coin_nx == COIN_DIME);
            busy_q     <= (state_nx != ST_IDLE);
            done_q     <= (state_nx == ST_DONE);
            drop_q     <= bus.soda_i && (state_q != ST_IDLE);
        end
    end

    assign bus.vend_motor_o = motor_q;
    assign bus.eject_req_o  = req_q;
    assign bus.eject_dime_o = dime_out_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.drop_o       = drop_q;
    assign bus.fault_o      = fault_q;
    assign bus.nickel_cnt_o = nickel_q;
    assign bus.dime_cnt_o   = dime_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser: a transaction-level model predicts
// coin sequences and end-of-transaction state into queues checked by a monitor.
module tb_change_dispenser;
    import vend_pkg::*;

    localparam int NI = 8;
    localparam int DI = 8;
    localparam int CW = 4;
    localparam int TO = 255;

    logic clk = 1'b0;
    logic rst;

    change_dispenser_if #(.CNT_W(CW)) bus();

    change_dispenser #(
        .NICKEL_INIT (NI),
        .DIME_INIT   (DI),
        .CNT_W       (CW),
        .ACK_TIMEOUT (TO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int d;
        int f;
    } done_rec_t;

    int        checks = 0;
    int        errors = 0;
    bit        ack_en = 1'b1;
    int        coin_q[$];
    done_rec_t done_q[$];
    int        m_n, m_d, m_f;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (bus.busy_o && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) chk("idle_wait_expired", int'(bus.busy_o), 0);
    endtask

    // Model: dimes while at least 10c owed and dimes remain, else nickels,
    // else fault with the remainder abandoned.
    task automatic issue(input logic [2:0] code, input bit with_refill, input bit acks);
        int        r;
        done_rec_t rec;
        wait_idle();
        bus.soda_i   = 1'b1;
        bus.change_i = code;
        bus.refill_i = with_refill;
        if (with_refill) begin
            m_n = NI; m_d = DI; m_f = 0;
        end
        if (code > 3'd4) begin
            m_f = 1;
        end else begin
            r = int'(code);
            if (!acks) begin
                if (r != 0) m_f = 1;
            end else begin
                while (r > 0) begin
                    if (r >= 2 && m_d > 0) begin
                        coin_q.push_back(1); m_d--; r -= 2;
                    end else if (m_n > 0) begin
                        coin_q.push_back(0); m_n--; r -= 1;
                    end else begin
                        m_f = 1; r = 0;
                    end
                end
            end
            rec.n = m_n; rec.d = m_d; rec.f = m_f;
            done_q.push_back(rec);
        end
        @(negedge clk);
        bus.soda_i   = 1'b0;
        bus.refill_i = 1'b0;
        if (code > 3'd4) begin
            chk("illegal_fault", int'(bus.fault_o), 1);
            chk("illegal_stays_idle", int'(bus.busy_o), 0);
        end else begin
            chk("accept_busy", int'(bus.busy_o), 1);
        end
    endtask

    task automatic refill();
        wait_idle();
        bus.refill_i = 1'b1;
        m_n = NI; m_d = DI; m_f = 0;
        @(negedge clk);
        bus.refill_i = 1'b0;
        chk("refill_fault_clr", int'(bus.fault_o), 0);
        chk("refill_nickels", int'(bus.nickel_cnt_o), NI);
        chk("refill_dimes", int'(bus.dime_cnt_o), DI);
    endtask

    task automatic drop_probe(input bit on_req);
        int k;
        k = 0;
        while (!(on_req ? bus.eject_req_o : bus.busy_o) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("drop_window_seen", int'(k < 100), 1);
        if (k < 100) begin
            bus.soda_i   = 1'b1;
            bus.change_i = 3'($urandom_range(0, 4));
            @(negedge clk);
            bus.soda_i = 1'b0;
            chk("drop_pulse", int'(bus.drop_o), 1);
            @(negedge clk);
            chk("drop_single", int'(bus.drop_o), 0);
        end
    endtask

    initial begin
        bus.vend_done_i = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.vend_motor_o && !bus.vend_done_i && $urandom_range(0, 2) == 0)
                bus.vend_done_i = 1'b1;
            else
                bus.vend_done_i = 1'b0;
        end
    end

    initial begin
        bus.eject_ack_i = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_en && bus.eject_req_o && !bus.eject_ack_i && $urandom_range(0, 2) == 0)
                bus.eject_ack_i = 1'b1;
            else
                bus.eject_ack_i = 1'b0;
        end
    end

    initial begin
        done_rec_t r;
        int        c;
        bit        prev_req, prev_dime;
        prev_req  = 1'b0;
        prev_dime = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
            end else begin
                if (bus.eject_req_o && prev_req)
                    chk("dime_stable", int'(bus.eject_dime_o), int'(prev_dime));
                if (bus.eject_req_o && bus.eject_ack_i) begin
                    chk("coin_expected", int'(coin_q.size() != 0), 1);
                    if (coin_q.size() != 0) begin
                        c = coin_q.pop_front();
                        chk("coin_dime", int'(bus.eject_dime_o), c);
                    end
                end
                if (bus.done_o) begin
                    chk("done_expected", int'(done_q.size() != 0), 1);
                    if (done_q.size() != 0) begin
                        r = done_q.pop_front();
                        chk("done_nickels", int'(bus.nickel_cnt_o), r.n);
                        chk("done_dimes", int'(bus.dime_cnt_o), r.d);
                        chk("done_fault", int'(bus.fault_o), r.f);
                        chk("done_coins_left", coin_q.size(), 0);
                        chk("done_motor_off", int'(bus.vend_motor_o), 0);
                        chk("done_req_off", int'(bus.eject_req_o), 0);
                    end
                end
                prev_req  = bus.eject_req_o;
                prev_dime = bus.eject_dime_o;
            end
        end
    end

    initial begin
        int k, n;
        logic [2:0] code;
        bus.soda_i   = 1'b0;
        bus.change_i = 3'd0;
        bus.refill_i = 1'b0;
        rst = 1'b1;
        m_n = NI; m_d = DI; m_f = 0;
        repeat (3) @(negedge clk);
        chk("rst_motor", int'(bus.vend_motor_o), 0);
        chk("rst_req", int'(bus.eject_req_o), 0);
        chk("rst_busy", int'(bus.busy_o), 0);
        chk("rst_done", int'(bus.done_o), 0);
        chk("rst_drop", int'(bus.drop_o), 0);
        chk("rst_fault", int'(bus.fault_o), 0);
        chk("rst_nickels", int'(bus.nickel_cnt_o), NI);
        chk("rst_dimes", int'(bus.dime_cnt_o), DI);
        rst = 1'b0;

        issue(CHG_0, 1'b0, 1'b1);
        issue(CHG_20, 1'b0, 1'b1);
        issue(CHG_15, 1'b0, 1'b1);
        wait_idle();
        chk("dir_nickels", int'(bus.nickel_cnt_o), 7);
        chk("dir_dimes", int'(bus.dime_cnt_o), 5);

        issue(CHG_20, 1'b0, 1'b1);
        drop_probe(1'b1);

        refill();
        for (int i = 0; i < 8; i++) issue(CHG_5, 1'b0, 1'b1);
        issue(CHG_5, 1'b0, 1'b1);
        wait_idle();
        chk("nickel_empty_fault", int'(bus.fault_o), 1);
        chk("nickel_empty_dimes", int'(bus.dime_cnt_o), 8);
        refill();
        for (int i = 0; i < 4; i++) issue(CHG_20, 1'b0, 1'b1);
        issue(CHG_10, 1'b0, 1'b1);
        wait_idle();
        chk("dime_empty_nickels", int'(bus.nickel_cnt_o), 6);
        chk("dime_empty_fault", int'(bus.fault_o), 0);
        issue(CHG_20, 1'b1, 1'b1);
        wait_idle();
        chk("refill_soda_dimes", int'(bus.dime_cnt_o), 6);
        chk("refill_soda_nickels", int'(bus.nickel_cnt_o), 8);

        issue(3'd6, 1'b0, 1'b1);
        refill();

        ack_en = 1'b0;
        issue(CHG_5, 1'b0, 1'b0);
        k = 0;
        while (!bus.eject_req_o && k < 100) begin @(negedge clk); k++; end
        n = 0;
        while (bus.eject_req_o && n < 1000) begin n++; @(negedge clk); end
        chk("timeout_len", n, TO);
        wait_idle();
        chk("timeout_fault", int'(bus.fault_o), 1);
        chk("timeout_nickels", int'(bus.nickel_cnt_o), NI);
        ack_en = 1'b1;
        refill();

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 11);
            code = (k < 10) ? 3'(k % 5) : 3'(5 + $urandom_range(0, 2));
            issue(code, $urandom_range(0, 7) == 0, 1'b1);
            if (code <= 3'd4 && $urandom_range(0, 4) == 0) drop_probe(1'b0);
        end

        refill();
        ack_en = 1'b0;
        issue(CHG_10, 1'b0, 1'b0);
        k = 0;
        while (!bus.eject_req_o && k < 100) begin @(negedge clk); k++; end
        chk("mid_eject_seen", int'(bus.eject_req_o), 1);
        issue_reset: begin
            bus.soda_i = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("abort_req", int'(bus.eject_req_o), 0);
        chk("abort_busy", int'(bus.busy_o), 0);
        chk("abort_done", int'(bus.done_o), 0);
        chk("abort_nickels", int'(bus.nickel_cnt_o), NI);
        chk("abort_dimes", int'(bus.dime_cnt_o), DI);
        coin_q.delete();
        done_q.delete();
        m_n = NI; m_d = DI; m_f = 0;
        ack_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_done", int'(bus.done_o), 0);
        issue(CHG_15, 1'b0, 1'b1);
        wait_idle();
        chk("end_coin_q_empty", coin_q.size(), 0);
        chk("end_done_q_empty", done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
